// File: rtl/gc_receive.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gc_receive : GameCube controller link receive deframer (pulse-width decode)
// Revision 1.0
// ---------------------------------------------------------------------------
module gc_receive #(
    parameter int LOW_THRESH   = 200,
    parameter int IDLE_TIMEOUT = 500,
    parameter int MAX_LOW      = 600
) (
    input  logic        clk100mhz,
    input  logic        reset,
    input  logic        data_in,
    input  logic        send,
    output logic [23:0] wavebird_id,
    output logic        wavebird_id_ready,
    output logic [63:0] button_data,
    output logic        button_data_ready,
    output logic        frame_error
);

    localparam logic [9:0] LOW_TH  = 10'(LOW_THRESH);
    localparam logic [9:0] IDLE_TO = 10'(IDLE_TIMEOUT);
    localparam logic [9:0] LOW_MAX = 10'(MAX_LOW);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOW       = 3'd1,
        ST_HIGH      = 3'd2,
        ST_END       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        sync_meta, s, s_prev;
    logic [9:0]  lo_cnt, lo_nxt, hi_cnt, hi_nxt;
    logic [6:0]  bit_cnt, bit_nxt;
    logic [64:0] shreg, shreg_nxt;
    logic        id_rdy_nxt, btn_rdy_nxt, err_nxt;
    logic        fall, rise;

    assign fall = s_prev & ~s;
    assign rise = s & ~s_prev;

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lo_nxt      = lo_cnt;
        hi_nxt      = hi_cnt;
        bit_nxt     = bit_cnt;
        shreg_nxt   = shreg;
        id_rdy_nxt  = 1'b0;
        btn_rdy_nxt = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                lo_nxt  = '0;
                hi_nxt  = '0;
                bit_nxt = '0;
                if (fall) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (lo_cnt >= LOW_MAX) begin
                    err_nxt   = 1'b1;
                    hi_nxt    = '0;
                    state_nxt = ST_WAIT_IDLE;
                end else if (rise) begin
                    hi_nxt = '0;
                    if (bit_cnt >= 7'd65) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end else begin
                        // Short low pulse is a 1; long low pulse is a 0.
                        shreg_nxt = {shreg[63:0], (lo_cnt < LOW_TH)};
                        bit_nxt   = bit_cnt + 7'd1;
                        state_nxt = ST_HIGH;
                    end
                end else if (!s) begin
                    lo_nxt = lo_cnt + 10'd1;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    lo_nxt    = '0;
                    state_nxt = ST_LOW;
                end else if (hi_cnt >= IDLE_TO) begin
                    state_nxt = ST_END;
                end else if (s) begin
                    hi_nxt = hi_cnt + 10'd1;
                end
            end
            ST_END: begin
                if (shreg[0] && bit_cnt == 7'd25)      id_rdy_nxt  = 1'b1;
                else if (shreg[0] && bit_cnt == 7'd65) btn_rdy_nxt = 1'b1;
                else                                   err_nxt     = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (hi_cnt >= IDLE_TO)  state_nxt = ST_IDLE;
                else if (s)             hi_nxt = hi_cnt + 10'd1;
                else                    hi_nxt = '0;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // The transmitter owning the line abandons any partial frame, but a
        // frame already in END still reports its result.
        if (send) begin
            state_nxt = ST_IDLE;
            lo_nxt    = '0;
            hi_nxt    = '0;
            bit_nxt   = '0;
            if (state != ST_END) begin
                id_rdy_nxt  = 1'b0;
                btn_rdy_nxt = 1'b0;
                err_nxt     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            sync_meta         <= 1'b1;
            s                 <= 1'b1;
            s_prev            <= 1'b1;
            lo_cnt            <= '0;
            hi_cnt            <= '0;
            bit_cnt           <= '0;
            shreg             <= '0;
            wavebird_id       <= '0;
            button_data       <= '0;
            wavebird_id_ready <= 1'b0;
            button_data_ready <= 1'b0;
            frame_error       <= 1'b0;
        end else begin
            sync_meta         <= data_in;
            s                 <= sync_meta;
            s_prev            <= s;
            lo_cnt            <= lo_nxt;
            hi_cnt            <= hi_nxt;
            bit_cnt           <= bit_nxt;
            shreg             <= shreg_nxt;
            wavebird_id_ready <= id_rdy_nxt;
            button_data_ready <= btn_rdy_nxt;
            frame_error       <= err_nxt;
            if (id_rdy_nxt)  wavebird_id <= shreg[24:1];
            if (btn_rdy_nxt) button_data <= shreg[64:1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gc_receive.sv
`default_nettype none
// Directed self-checking bench for gc_receive: drives pulse-width frames on
// data_in and checks outputs, strobe counts and stop-bit-to-strobe latency.
module tb_gc_receive;

    logic        clk100mhz = 1'b0;
    logic        reset     = 1'b1;
    logic        data_in   = 1'b1;
    logic        send      = 1'b0;
    logic [23:0] wavebird_id;
    logic        wavebird_id_ready;
    logic [63:0] button_data;
    logic        button_data_ready;
    logic        frame_error;

    gc_receive dut (
        .clk100mhz         (clk100mhz),
        .reset             (reset),
        .data_in           (data_in),
        .send              (send),
        .wavebird_id       (wavebird_id),
        .wavebird_id_ready (wavebird_id_ready),
        .button_data       (button_data),
        .button_data_ready (button_data_ready),
        .frame_error       (frame_error)
    );

    always #5 clk100mhz = ~clk100mhz;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int id_cnt = 0, btn_cnt = 0, err_cnt = 0, multi_cnt = 0;
    int id_cyc = 0, err_cyc = 0;
    int rise_cyc = 0;
    bit slow = 1'b1;

    always @(posedge clk100mhz) cyc++;

    always @(negedge clk100mhz) begin
        if (wavebird_id_ready === 1'b1) begin id_cnt++; id_cyc = cyc; end
        if (button_data_ready === 1'b1) btn_cnt++;
        if (frame_error === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if ((32'(wavebird_id_ready) + 32'(button_data_ready) + 32'(frame_error)) > 1) multi_cnt++;
    end

    // Caller is positioned at a negedge; returns positioned at a negedge.
    task automatic drive_bit(input logic b);
        data_in = 1'b0;
        repeat (b ? 100 : 300) @(negedge clk100mhz);
        data_in = 1'b1;
        repeat (slow ? (b ? 300 : 100) : 100) @(negedge clk100mhz);
    endtask

    task automatic drive_frame(input logic [63:0] val, input int n, input logic stop);
        for (int i = n - 1; i >= 0; i--) drive_bit(val[i]);
        data_in = 1'b0;
        repeat (stop ? 100 : 300) @(negedge clk100mhz);
        data_in = 1'b1;
        rise_cyc = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk100mhz);
        checks++; if (wavebird_id !== 24'h0) $display("FAIL reset_id: got %h want %h", wavebird_id, 24'h0); else passes++;
        checks++; if (button_data !== 64'h0) $display("FAIL reset_btn: got %h want %h", button_data, 64'h0); else passes++;
        checks++; if ({wavebird_id_ready, button_data_ready, frame_error} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000", {wavebird_id_ready, button_data_ready, frame_error});
        else passes++;
        reset = 1'b0;
        repeat (20) @(negedge clk100mhz);
    endtask

    task automatic test_id_reply();
        int id0, btn0, err0;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        drive_frame(64'hA81234, 24, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt - id0 != 1) $display("FAIL id_ready_count: got %0d want 1", id_cnt - id0); else passes++;
        checks++; if (wavebird_id !== 24'hA81234) $display("FAIL id_value: got %h want a81234", wavebird_id); else passes++;
        // Latency counted from the first clock edge that samples the stop-bit rise.
        checks++; if (id_cyc - (rise_cyc + 1) != 504) $display("FAIL id_latency: got %0d want 504", id_cyc - (rise_cyc + 1)); else passes++;
        checks++; if (btn_cnt != btn0 || err_cnt != err0)
            $display("FAIL id_other_strobes: got btn %0d err %0d want 0 0", btn_cnt - btn0, err_cnt - err0);
        else passes++;
        checks++; if (button_data !== 64'h0) $display("FAIL id_btn_hold: got %h want 0", button_data); else passes++;
    endtask

    task automatic test_poll_reply();
        int id0, btn0, err0;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        drive_frame(64'h0080_8080_8080_1F1F, 64, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (btn_cnt - btn0 != 1) $display("FAIL poll_ready_count: got %0d want 1", btn_cnt - btn0); else passes++;
        checks++; if (button_data !== 64'h0080_8080_8080_1F1F) $display("FAIL poll_value: got %h want 0080808080801f1f", button_data); else passes++;
        checks++; if (wavebird_id !== 24'hA81234) $display("FAIL poll_id_hold: got %h want a81234", wavebird_id); else passes++;
        checks++; if (id_cnt != id0 || err_cnt != err0)
            $display("FAIL poll_other_strobes: got id %0d err %0d want 0 0", id_cnt - id0, err_cnt - err0);
        else passes++;
    endtask

    task automatic test_bad_length();
        int id0, btn0, err0;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        drive_frame(64'h00, 8, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (err_cnt - err0 != 1) $display("FAIL short_frame_err: got %0d want 1", err_cnt - err0); else passes++;
        checks++; if (id_cnt != id0 || btn_cnt != btn0)
            $display("FAIL short_frame_ready: got id %0d btn %0d want 0 0", id_cnt - id0, btn_cnt - btn0);
        else passes++;
        err0 = err_cnt;
        drive_frame(64'hFFFFFF, 24, 1'b0);
        repeat (600) @(negedge clk100mhz);
        checks++; if (err_cnt - err0 != 1) $display("FAIL bad_stop_err: got %0d want 1", err_cnt - err0); else passes++;
        checks++; if (id_cnt != id0) $display("FAIL bad_stop_ready: got %0d want 0", id_cnt - id0); else passes++;
        checks++; if (wavebird_id !== 24'hA81234) $display("FAIL bad_stop_id_hold: got %h want a81234", wavebird_id); else passes++;
    endtask

    task automatic test_stuck_low();
        int id0, btn0, err0, f;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        data_in = 1'b0;
        f = cyc;
        repeat (700) @(negedge clk100mhz);
        data_in = 1'b1;
        repeat (600) @(negedge clk100mhz);
        checks++; if (err_cnt - err0 != 1) $display("FAIL stuck_err_count: got %0d want 1", err_cnt - err0); else passes++;
        // 2 sync + 1 edge detect + 600 low counts + 1 registered strobe
        checks++; if (err_cyc - f != 604) $display("FAIL stuck_err_time: got %0d want 604", err_cyc - f); else passes++;
        checks++; if (id_cnt != id0 || btn_cnt != btn0)
            $display("FAIL stuck_ready: got id %0d btn %0d want 0 0", id_cnt - id0, btn_cnt - btn0);
        else passes++;
        drive_frame(64'h123456, 24, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt - id0 != 1) $display("FAIL stuck_recover_count: got %0d want 1", id_cnt - id0); else passes++;
        checks++; if (wavebird_id !== 24'h123456) $display("FAIL stuck_recover_id: got %h want 123456", wavebird_id); else passes++;
    endtask

    task automatic test_abort();
        int id0, btn0, err0;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        for (int i = 63; i >= 54; i--) drive_bit(logic'(64'h0080_8080_8080_1F1F >> i));
        send = 1'b1;
        repeat (30) @(negedge clk100mhz);
        send = 1'b0;
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt != id0 || btn_cnt != btn0 || err_cnt != err0)
            $display("FAIL abort_strobes: got id %0d btn %0d err %0d want 0 0 0", id_cnt - id0, btn_cnt - btn0, err_cnt - err0);
        else passes++;
        checks++; if (button_data !== 64'h0080_8080_8080_1F1F) $display("FAIL abort_btn_hold: got %h want 0080808080801f1f", button_data); else passes++;
        checks++; if (wavebird_id !== 24'h123456) $display("FAIL abort_id_hold: got %h want 123456", wavebird_id); else passes++;
        drive_frame(64'hC3A55A, 24, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt - id0 != 1) $display("FAIL abort_recover_count: got %0d want 1", id_cnt - id0); else passes++;
        checks++; if (wavebird_id !== 24'hC3A55A) $display("FAIL abort_recover_id: got %h want c3a55a", wavebird_id); else passes++;
    endtask

    task automatic test_mid_reset();
        int id0, btn0, err0;
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        reset = 1'b1;
        @(negedge clk100mhz);
        reset = 1'b0;
        checks++; if (wavebird_id !== 24'h0) $display("FAIL midreset_id: got %h want 0", wavebird_id); else passes++;
        checks++; if (button_data !== 64'h0) $display("FAIL midreset_btn: got %h want 0", button_data); else passes++;
        id0 = id_cnt; btn0 = btn_cnt; err0 = err_cnt;
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt != id0 || btn_cnt != btn0 || err_cnt != err0)
            $display("FAIL midreset_strobes: got id %0d btn %0d err %0d want 0 0 0", id_cnt - id0, btn_cnt - btn0, err_cnt - err0);
        else passes++;
        drive_frame(64'h5A5AF0, 24, 1'b1);
        repeat (600) @(negedge clk100mhz);
        checks++; if (id_cnt - id0 != 1) $display("FAIL midreset_recover_count: got %0d want 1", id_cnt - id0); else passes++;
        checks++; if (wavebird_id !== 24'h5A5AF0) $display("FAIL midreset_recover_id: got %h want 5a5af0", wavebird_id); else passes++;
        checks++; if (button_data !== 64'h0) $display("FAIL midreset_btn_hold: got %h want 0", button_data); else passes++;
    endtask

    initial begin
        @(negedge clk100mhz);
        test_reset();
        test_id_reply();
        slow = 1'b0;
        test_poll_reply();
        test_bad_length();
        test_stuck_low();
        test_abort();
        test_mid_reset();
        checks++; if (multi_cnt != 0) $display("FAIL strobe_overlap: got %0d want 0", multi_cnt); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
